// File: rtl/autoplay_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : autoplay_sequencer_pkg
//  Purpose  : Shared constants for the song-playback path: note/duration
//             widths, note codes shared with the learning-mode logic and the
//             song memory, and the autoplay state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package autoplay_sequencer_pkg;

    localparam int NOTE_W  = 4;
    localparam int DUR_W   = 26;
    localparam int STATE_W = 3;

    localparam logic [NOTE_W-1:0] END_NOTE  = 4'd15;
    localparam logic [NOTE_W-1:0] REST_NOTE = 4'd0;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH = 3'd1;
    localparam logic [STATE_W-1:0] S_LOAD  = 3'd2;
    localparam logic [STATE_W-1:0] S_PLAY  = 3'd3;
    localparam logic [STATE_W-1:0] S_GAP   = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd5;

    // A stored duration of zero still sounds for one clock.
    function automatic logic [DUR_W-1:0] min_one(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/duration_timer.sv
`default_nettype none
// ============================================================================
//  Module   : duration_timer
//  Purpose  : DUR_W-bit loadable down-counter with enable and clear. o_expire
//             is high during the last enabled count, so a load of N yields
//             exactly N enabled cycles before the owner sees expiry.
//  Ports    : clk, rst         clock / synchronous active-high reset
//             i_clear          force count to zero
//             i_load           load i_load_value (wins over counting)
//             i_load_value     new count
//             i_enable         count down this cycle
//             o_expire         final enabled cycle of the loaded interval
//  Revision : 1.0  initial release
// ============================================================================
module duration_timer
    import autoplay_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [DUR_W-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_expire
);

    logic [DUR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - DUR_W'(1);
        end
    end

    // Depends only on enable and the count, never on load/clear, so the
    // owner may decide its next load from this signal without a loop.
    assign o_expire = i_enable && (r_count == DUR_W'(1));

endmodule
`default_nettype wire

// File: rtl/autoplay_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : autoplay_sequencer
//  Purpose  : Plays the stored song through the note datapath. Walks song
//             memory, sounds each note for its stored duration, inserts a
//             silent gap between notes, stops on END_NOTE, on the last entry
//             or on stop, and freezes while pause is high.
//  Ports    : clk, rst                  clock / synchronous active-high reset
//             start                     begin playback (IDLE only)
//             stop                      abort playback
//             pause                     level, freezes PLAY and GAP
//             note_value/duration_value song memory read data (1-cycle latency)
//             mem_addr                  song memory read address
//             key, key_on               note and sound enable to datapath
//             busy                      not IDLE
//             done                      one-cycle pulse on normal completion
//  Revision : 1.0  initial release
// ============================================================================
module autoplay_sequencer
    import autoplay_sequencer_pkg::*;
#(
    parameter int                ADDR_W     = 5,
    parameter int                MEM_DEPTH  = 32,
    parameter int                GAP_CYCLES = 5_000_000,
    parameter logic [NOTE_W-1:0] END_NOTE   = autoplay_sequencer_pkg::END_NOTE,
    parameter logic [NOTE_W-1:0] REST_NOTE  = autoplay_sequencer_pkg::REST_NOTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [NOTE_W-1:0] note_value,
    input  logic [DUR_W-1:0]  duration_value,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [NOTE_W-1:0] key,
    output logic              key_on,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [DUR_W-1:0]  c_GAP_LOAD  = DUR_W'(GAP_CYCLES);
    localparam logic              c_HAS_GAP   = (GAP_CYCLES > 0);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [NOTE_W-1:0]  r_key;

    logic               w_timer_load;
    logic [DUR_W-1:0]   w_timer_value;
    logic               w_timer_en;
    logic               w_timer_clear;
    logic               w_expire;
    logic               w_addr_inc;
    logic               w_addr_clr;
    logic               w_key_load;
    logic               w_key_clr;

    duration_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_timer_clear),
        .i_load       (w_timer_load),
        .i_load_value (w_timer_value),
        .i_enable     (w_timer_en),
        .o_expire     (w_expire)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_load  = 1'b0;
        w_timer_value = min_one(duration_value);
        w_timer_en    = 1'b0;
        w_timer_clear = 1'b0;
        w_addr_inc    = 1'b0;
        w_addr_clr    = 1'b0;
        w_key_load    = 1'b0;
        w_key_clr     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = S_FETCH;
                    w_addr_clr  = 1'b1;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_key_load = 1'b1;
                if (note_value == END_NOTE) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt  = S_PLAY;
                    w_timer_load = 1'b1;
                end
            end
            S_PLAY: begin
                w_timer_en = !pause;
                if (w_expire) begin
                    if (r_addr == c_LAST_ADDR) begin
                        w_state_nxt = S_DONE;
                    end else if (c_HAS_GAP) begin
                        w_state_nxt   = S_GAP;
                        w_timer_load  = 1'b1;
                        w_timer_value = c_GAP_LOAD;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_addr_inc  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                w_timer_en = !pause;
                if (w_expire) begin
                    w_state_nxt = S_FETCH;
                    w_addr_inc  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_addr_clr  = 1'b1;
                w_key_clr   = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_addr_clr  = 1'b1;
                w_key_clr   = 1'b1;
            end
        endcase

        // Abort overrides every decision taken above, including expiry and
        // the END_NOTE branch; no done pulse results.
        if (stop && (r_state != S_IDLE)) begin
            w_state_nxt   = S_IDLE;
            w_timer_load  = 1'b0;
            w_timer_clear = 1'b1;
            w_addr_inc    = 1'b0;
            w_addr_clr    = 1'b1;
            w_key_load    = 1'b0;
            w_key_clr     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_addr_clr) begin
                r_addr <= '0;
            end else if (w_addr_inc) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_key_clr) begin
                r_key <= '0;
            end else if (w_key_load) begin
                r_key <= note_value;
            end
        end
    end

    assign mem_addr = r_addr;
    assign key      = r_key;
    assign key_on   = (r_state == S_PLAY) && (r_key != REST_NOTE) && !pause;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_autoplay_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_autoplay_sequencer
//  Purpose  : Self-checking bench for autoplay_sequencer (MEM_DEPTH=8,
//             GAP_CYCLES=2). A reference timing model expands the song
//             memory into a per-cycle expected trace held in a queue; each
//             clock the DUT outputs are compared against the popped entry.
//  Revision : 1.0  initial release
// ============================================================================
module tb_autoplay_sequencer;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int GAP    = 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        pause;
    logic [3:0]  note_value;
    logic [25:0] duration_value;
    logic [2:0]  mem_addr;
    logic [3:0]  key;
    logic        key_on;
    logic        busy;
    logic        done;

    logic [3:0]  mem_note [DEPTH];
    logic [25:0] mem_dur  [DEPTH];

    typedef struct {
        bit         busy;
        bit         key_on;
        bit         done;
        logic [2:0] addr;
        bit         kchk;
        logic [3:0] key;
    } exp_t;

    exp_t sb[$];

    int n_cmp;
    int n_err;
    int on_cnt;
    int done_cnt;
    int done_idx;
    int g_plo;
    int g_phi;

    autoplay_sequencer #(
        .ADDR_W     (ADDR_W),
        .MEM_DEPTH  (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .pause          (pause),
        .note_value     (note_value),
        .duration_value (duration_value),
        .mem_addr       (mem_addr),
        .key            (key),
        .key_on         (key_on),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Song memory with one cycle of read latency.
    always @(posedge clk) begin
        note_value     <= mem_note[mem_addr];
        duration_value <= mem_dur[mem_addr];
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void push_e(bit b, bit ko, bit d, int a, bit kc, int k);
        exp_t e;
        e.busy = b; e.key_on = ko; e.done = d;
        e.addr = 3'(a); e.kchk = kc; e.key = 4'(k);
        sb.push_back(e);
    endfunction

    function automatic bit paused_at(int idx);
        return (idx >= g_plo) && (idx <= g_phi);
    endfunction

    // Reference model: cycle 0 is the cycle after the edge that samples start.
    function automatic void build_expected();
        int addr;
        int n;
        int d;
        int g;
        bit p;
        addr = 0;
        for (int guard = 0; guard < 2 * DEPTH; guard++) begin
            push_e(1, 0, 0, addr, 0, 0);             // FETCH
            push_e(1, 0, 0, addr, 0, 0);             // LOAD
            n = int'(mem_note[addr]);
            d = (mem_dur[addr] == 26'd0) ? 1 : int'(mem_dur[addr]);
            if (n == 15) begin
                push_e(1, 0, 1, addr, 0, 0);         // DONE
                break;
            end
            while (d > 0) begin
                p = paused_at(sb.size());
                push_e(1, (n != 0) && !p, 0, addr, 1, n);
                if (!p) d--;
            end
            if (addr == DEPTH - 1) begin
                push_e(1, 0, 1, addr, 0, 0);         // DONE, no wrap
                break;
            end
            g = GAP;
            while (g > 0) begin
                p = paused_at(sb.size());
                push_e(1, 0, 0, addr, 1, n);
                if (!p) g--;
            end
            addr++;
        end
        push_e(0, 0, 0, 0, 0, 0);
    endfunction

    task automatic set_entry(input int a, input int n, input int d);
        mem_note[a] = 4'(n);
        mem_dur[a]  = 26'(d);
    endtask

    task automatic fill_mem(input int n, input int d);
        for (int a = 0; a < DEPTH; a++) set_entry(a, n, d);
    endtask

    // kill_at >= 0: stop (or rst if kill_rst) is held during that cycle.
    // restart_at >= 0: a start pulse is driven during that cycle.
    task automatic run_song(input string name, input int p_lo, input int p_hi,
                            input int kill_at, input bit kill_rst,
                            input int restart_at);
        exp_t e;
        int   i;
        g_plo = p_lo;
        g_phi = p_hi;
        sb.delete();
        build_expected();
        if (kill_at >= 0) begin
            while (sb.size() > kill_at + 1) void'(sb.pop_back());
            for (int j = 0; j < 3; j++) push_e(0, 0, 0, 0, kill_rst, 0);
        end
        on_cnt   = 0;
        done_cnt = 0;
        done_idx = -1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        i = 0;
        while (sb.size() > 0) begin
            pause = paused_at(i);
            stop  = !kill_rst && (i == kill_at);
            rst   = kill_rst && (i == kill_at);
            start = (i == restart_at);
            @(negedge clk);
            e = sb.pop_front();
            check_val($sformatf("%s_c%0d_busy", name, i), int'(busy), int'(e.busy));
            check_val($sformatf("%s_c%0d_keyon", name, i), int'(key_on), int'(e.key_on));
            check_val($sformatf("%s_c%0d_done", name, i), int'(done), int'(e.done));
            check_val($sformatf("%s_c%0d_addr", name, i), int'(mem_addr), int'(e.addr));
            if (e.kchk)
                check_val($sformatf("%s_c%0d_key", name, i), int'(key), int'(e.key));
            if (key_on) on_cnt++;
            if (done) begin
                done_cnt++;
                done_idx = i;
            end
            @(posedge clk); #1;
            i++;
        end
        pause = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        fill_mem(15, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_key", int'(key), 0);
        check_val("rst_keyon", int'(key_on), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_addr", int'(mem_addr), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: two notes with gaps, END at address 2
        fill_mem(15, 0);
        set_entry(0, 1, 3);
        set_entry(1, 5, 2);
        run_song("t1", -1, -2, -1, 1'b0, -1);
        check_val("t1_on_cycles", on_cnt, 5);
        check_val("t1_done_count", done_cnt, 1);
        check_val("t1_done_cycle", done_idx, 15);

        // 2: pause for 4 cycles after 2 cycles of PLAY
        fill_mem(15, 0);
        set_entry(0, 3, 5);
        run_song("t2", 4, 7, -1, 1'b0, -1);
        check_val("t2_on_cycles", on_cnt, 5);
        check_val("t2_done_cycle", done_idx, 15);

        // 3: stop in the second GAP cycle
        fill_mem(6, 4);
        set_entry(0, 2, 4);
        run_song("t3", -1, -2, 7, 1'b0, -1);
        check_val("t3_done_count", done_cnt, 0);

        // 4: rest note, short note, zero-duration note
        fill_mem(15, 0);
        set_entry(0, 0, 4);
        set_entry(1, 7, 1);
        set_entry(2, 9, 0);
        run_song("t4", -1, -2, -1, 1'b0, -1);
        check_val("t4_on_cycles", on_cnt, 2);

        // 5: full memory, stops after the last address
        for (int a = 0; a < DEPTH; a++) set_entry(a, a + 1, 1);
        run_song("t5", -1, -2, -1, 1'b0, -1);
        check_val("t5_on_cycles", on_cnt, 8);
        check_val("t5_done_count", done_cnt, 1);

        // 6a: start and stop together in IDLE
        @(posedge clk); #1;
        start = 1'b1;
        stop  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_val($sformatf("t6a_c%0d_busy", j), int'(busy), 0);
            check_val($sformatf("t6a_c%0d_addr", j), int'(mem_addr), 0);
        end

        // 6b: start while busy is ignored
        fill_mem(15, 0);
        set_entry(0, 1, 3);
        set_entry(1, 5, 2);
        run_song("t6b", -1, -2, -1, 1'b0, 3);
        check_val("t6b_done_count", done_cnt, 1);

        // 6c: rst in the second PLAY cycle
        run_song("t6c", -1, -2, 3, 1'b1, -1);
        check_val("t6c_done_count", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
